stimulus_checker_3input: RTL and testbench

//  Clocked stimulus sequencer and equivalence checker for the 3-input circuit family (switch, assign and gate forms).
//  - Upstream role: drives a/b/c into all three implementations from a fixed vector table.
//  - Downstream role: collects each implementation's y1/y0 pair and flags any disagreement.
//  - Replaces hand-timed #delay stimulus with a self-checking, synthesizable run controller.

---
 rtl/stim3_pkg.sv | 32 +++
 rtl/vector_rom_3input.sv | 38 +++
 rtl/stimulus_checker_3input.sv | 189 ++++++++++++++++++
 tb/tb_stimulus_checker_3input.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stim3_pkg.sv
// ---------------------------------------------------------------------------
// stim3_pkg
//   Shared definitions for the 3-input stimulus sequencer / equivalence
//   checker.
//   - state_t    : run-controller FSM states
//   - WALK_TABLE : walking-ones style vector table, entries are {a,b,c}
//   - num_vec()  : number of vectors in a run for a given sequence mode
// ---------------------------------------------------------------------------
package stim3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int unsigned WALK_LEN = 7;
  localparam int unsigned BIN_LEN  = 8;

  // Entries are {a,b,c}: ones walk in from a, then walk out from a.
  localparam logic [2:0] WALK_TABLE [0:WALK_LEN-1] = '{
    3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000
  };

  // SEQ_MODE 0 walks WALK_TABLE, any other value counts 000..111.
  function automatic int unsigned num_vec(input int unsigned seq_mode);
    return (seq_mode == 0) ? WALK_LEN : BIN_LEN;
  endfunction

endpackage

// File: rtl/vector_rom_3input.sv
// ---------------------------------------------------------------------------
// vector_rom_3input
//   Purely combinational vector source for the stimulus sequencer.
//   Parameters:
//     SEQ_MODE  0 = walk table (7 entries), 1 = binary count (8 entries)
//   Ports:
//     idx   in   3   vector index
//     vec   out  3   {a,b,c} for that index (000 past the end of the walk)
// ---------------------------------------------------------------------------
module vector_rom_3input
  import stim3_pkg::*;
#(
  parameter int unsigned SEQ_MODE = 0
) (
  input  logic [2:0] idx,
  output logic [2:0] vec
);

  always_comb begin
    vec = 3'b000;
    if (SEQ_MODE == 0) begin
      case (idx)
        3'd0:    vec = WALK_TABLE[0];
        3'd1:    vec = WALK_TABLE[1];
        3'd2:    vec = WALK_TABLE[2];
        3'd3:    vec = WALK_TABLE[3];
        3'd4:    vec = WALK_TABLE[4];
        3'd5:    vec = WALK_TABLE[5];
        3'd6:    vec = WALK_TABLE[6];
        default: vec = 3'b000;
      endcase
    end else begin
      // Binary count: the vector is the index itself.
      vec = idx;
    end
  end

endmodule

// File: rtl/stimulus_checker_3input.sv
// ---------------------------------------------------------------------------
// stimulus_checker_3input
//   Clocked stimulus sequencer and equivalence checker for the 3-input
//   circuit family (switch, assign and gate implementations). Drives a/b/c
//   from a vector table, waits SETTLE_CYCLES, compares the three {y1,y0}
//   pairs for one cycle, then holds the vector until HOLD_CYCLES have
//   elapsed before moving to the next one.
//
//   Parameters:
//     HOLD_CYCLES    cycles each vector is held (>= SETTLE_CYCLES+1)
//     SETTLE_CYCLES  cycles after a vector is applied before comparing (>= 1)
//     SEQ_MODE       0 = walk table (7 vectors), 1 = binary count (8 vectors)
//
//   Ports:
//     clk              in   1  rising-edge clock
//     rst              in   1  synchronous active-high reset
//     start            in   1  begin a run
//     a, b, c          out  1  stimulus to all three implementations
//     y1_sw, y0_sw     in   1  switch-level outputs
//     y1_as, y0_as     in   1  assign-level outputs
//     y1_gt, y0_gt     in   1  gate-level outputs
//     busy             out  1  run in progress
//     done             out  1  level, high in DONE
//     err_count        out  4  vectors that failed comparison this run
//     first_err_valid  out  1  a failure has been recorded this run
//     first_err_vec    out  3  {a,b,c} of the first failing vector
//     state_dbg        out  3  current FSM state (stim3_pkg::state_t encoding)
//
//   Start handshake: start is a request sampled on every rising edge; it is
//   accepted on an edge where the FSM is in IDLE or DONE (busy low) and is
//   silently dropped while busy is high. There is no acknowledge other than
//   busy rising after the accepting edge.
// ---------------------------------------------------------------------------
module stimulus_checker_3input
  import stim3_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 10,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned SEQ_MODE      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       y1_sw,
  input  logic       y0_sw,
  input  logic       y1_as,
  input  logic       y0_as,
  input  logic       y1_gt,
  input  logic       y0_gt,
  output logic       busy,
  output logic       done,
  output logic [3:0] err_count,
  output logic       first_err_valid,
  output logic [2:0] first_err_vec,
  output logic [2:0] state_dbg
);

  // cnt only ever reaches HOLD_CYCLES-1.
  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX    = 3'(num_vec(SEQ_MODE) - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [2:0]    abc;

  logic [2:0]    rom_idx;
  logic [2:0]    rom_vec;
  logic          adv;
  logic          pass;

  // The ROM is addressed with the index that is about to be loaded:
  // vector 0 when starting, otherwise the next vector.
  always_comb begin
    rom_idx = idx + 3'd1;
    if (state == ST_IDLE || state == ST_DONE) begin
      rom_idx = 3'd0;
    end
  end

  vector_rom_3input #(
    .SEQ_MODE (SEQ_MODE)
  ) u_rom (
    .idx (rom_idx),
    .vec (rom_vec)
  );

  // All three implementations must agree on both output bits.
  assign pass = ({y1_sw, y0_sw} == {y1_as, y0_as}) &&
                ({y1_as, y0_as} == {y1_gt, y0_gt});

  // Advance when the current vector has been held for HOLD_CYCLES.
  // CHECK can itself be the last cycle when HOLD_CYCLES == SETTLE_CYCLES+1.
  always_comb begin
    adv = 1'b0;
    if (state == ST_CHECK) begin
      adv = (cnt >= HOLD_LAST);
    end else if (state == ST_HOLD) begin
      adv = (cnt == HOLD_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      idx             <= 3'd0;
      abc             <= 3'b000;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_count       <= 4'd0;
      first_err_valid <= 1'b0;
      first_err_vec   <= 3'b000;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err_count       <= 4'd0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 3'b000;
            idx             <= 3'd0;
            abc             <= rom_vec;
            cnt             <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            state           <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == SETTLE_LAST) begin
            state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (!pass) begin
            err_count <= err_count + 4'd1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= abc;
            end
          end
          if (!adv) begin
            cnt   <= cnt + 1'b1;
            state <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (!adv) begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Vector boundary: either finish the run or load the next vector.
      if (adv) begin
        if (idx == LAST_IDX) begin
          abc   <= 3'b000;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end else begin
          idx   <= idx + 3'd1;
          abc   <= rom_vec;
          cnt   <= '0;
          state <= ST_SETTLE;
        end
      end
    end
  end

  assign a         = abc[2];
  assign b         = abc[1];
  assign c         = abc[0];
  assign state_dbg = state;

endmodule

// File: tb/tb_stimulus_checker_3input.sv
module tb_stimulus_checker_3input;

  localparam int HOLD   = 4;
  localparam int SETTLE = 2;
  localparam int W      = 5;   // {abc[2:0], busy, done}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_w, start_b;
  logic y1_sw, y0_sw, y1_as, y0_as, y1_gt, y0_gt;

  logic       a_w, b_w, c_w, busy_w, done_w, fv_w;
  logic [3:0] err_w;
  logic [2:0] fvec_w, st_w;
  logic       a_b, b_b, c_b, busy_b, done_b, fv_b;
  logic [3:0] err_b;
  logic [2:0] fvec_b, st_b;

  stimulus_checker_3input #(
    .HOLD_CYCLES (HOLD), .SETTLE_CYCLES (SETTLE), .SEQ_MODE (0)
  ) dut_w (
    .clk (clk), .rst (rst), .start (start_w),
    .a (a_w), .b (b_w), .c (c_w),
    .y1_sw (y1_sw), .y0_sw (y0_sw), .y1_as (y1_as), .y0_as (y0_as),
    .y1_gt (y1_gt), .y0_gt (y0_gt),
    .busy (busy_w), .done (done_w), .err_count (err_w),
    .first_err_valid (fv_w), .first_err_vec (fvec_w), .state_dbg (st_w)
  );

  stimulus_checker_3input #(
    .HOLD_CYCLES (HOLD), .SETTLE_CYCLES (SETTLE), .SEQ_MODE (1)
  ) dut_b (
    .clk (clk), .rst (rst), .start (start_b),
    .a (a_b), .b (b_b), .c (c_b),
    .y1_sw (y1_sw), .y0_sw (y0_sw), .y1_as (y1_as), .y0_as (y0_as),
    .y1_gt (y1_gt), .y0_gt (y0_gt),
    .busy (busy_b), .done (done_b), .err_count (err_b),
    .first_err_valid (fv_b), .first_err_vec (fvec_b), .state_dbg (st_b)
  );

  // Outputs of the instance currently being exercised.
  int         cur_mode = 0;
  logic [2:0] abc_s, fvec_s;
  logic [3:0] err_s;
  logic       busy_s, done_s, fv_s;
  always_comb begin
    if (cur_mode == 1) begin
      abc_s = {a_b, b_b, c_b}; busy_s = busy_b; done_s = done_b;
      err_s = err_b; fv_s = fv_b; fvec_s = fvec_b;
    end else begin
      abc_s = {a_w, b_w, c_w}; busy_s = busy_w; done_s = done_w;
      err_s = err_w; fv_s = fv_w; fvec_s = fvec_w;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int num_vec(input int mode);
    return (mode == 0) ? 7 : 8;
  endfunction

  function automatic logic [2:0] exp_vec(input int mode, input int i);
    logic [2:0] walk [0:6];
    walk = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
    if (mode == 0) return walk[i];
    return 3'(i);
  endfunction

  // Drive the three implementation outputs for vector v; phase is the
  // cycle within the vector the DUT will be in when it samples them
  // (phase SETTLE is the single compare cycle).
  //   fault 0: all agree
  //   fault 1: gate y1 inverted only for 111
  //   fault 2: switch y0 stuck at 1, others 0
  //   fault 3: random gate y0 glitches outside the compare cycle
  task automatic set_y(input int fault, input logic [2:0] v, input int phase);
    logic r1, r0;
    r1 = (v[2] & v[1]) | v[0];
    r0 = ^v;
    y1_sw = r1; y0_sw = r0; y1_as = r1; y0_as = r0; y1_gt = r1; y0_gt = r0;
    case (fault)
      1: if (v == 3'b111) y1_gt = ~r1;
      2: begin
        y1_sw = 1'b0; y0_sw = 1'b1; y1_as = 1'b0; y0_as = 1'b0;
        y1_gt = 1'b0; y0_gt = 1'b0;
      end
      3: if (phase != SETTLE && $urandom_range(0, 3) != 0) y0_gt = ~r0;
      default: ;
    endcase
  endtask

  task automatic pulse_start(input int mode, input logic val);
    if (mode == 1) start_b = val; else start_w = val;
  endtask

  // ---------------- run records ----------------
  typedef struct {
    int         mode;
    int         fault;
    int         restart_at;   // cycle after start edge where start is re-pulsed, -1 none
    int         exp_err;
    logic       exp_fv;
    logic [2:0] exp_fvec;
  } run_t;

  // Full run: expectations for every cycle are queued when the start is
  // driven, then popped and compared one per cycle.
  task automatic do_run(input run_t r, input string tag);
    int n;
    n = num_vec(r.mode);
    cur_mode = r.mode;
    for (int k = 0; k <= n * HOLD; k++) begin
      if (k < n * HOLD) exp_q.push_back({exp_vec(r.mode, k / HOLD), 1'b1, 1'b0});
      else              exp_q.push_back({3'b000, 1'b0, 1'b1});
    end
    @(negedge clk);
    pulse_start(r.mode, 1'b1);
    @(posedge clk);
    #1;
    pulse_start(r.mode, 1'b0);
    for (int k = 0; k <= n * HOLD; k++) begin
      logic [W-1:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      check({tag, "_abc_busy_done"}, 32'({abc_s, busy_s, done_s}), 32'(e));
      if (k == 0) begin
        check({tag, "_err_cleared"}, 32'(err_s), 32'd0);
        check({tag, "_fv_cleared"}, 32'(fv_s), 32'd0);
      end
      if (k < n * HOLD) set_y(r.fault, exp_vec(r.mode, k / HOLD), k % HOLD);
      pulse_start(r.mode, (k + 1 == r.restart_at) ? 1'b1 : 1'b0);
    end
    check({tag, "_err_count"}, 32'(err_s), 32'(r.exp_err));
    check({tag, "_first_err_valid"}, 32'(fv_s), 32'(r.exp_fv));
    check({tag, "_first_err_vec"}, 32'(fvec_s), 32'(r.exp_fvec));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_w_outs"}, 32'({a_w, b_w, c_w, busy_w, done_w, fv_w}), 32'd0);
    check({tag, "_w_err"}, 32'({err_w, fvec_w}), 32'd0);
    check({tag, "_w_state"}, 32'(st_w), 32'd0);
    check({tag, "_b_outs"}, 32'({a_b, b_b, c_b, busy_b, done_b, fv_b}), 32'd0);
    check({tag, "_b_err"}, 32'({err_b, fvec_b}), 32'd0);
    check({tag, "_b_state"}, 32'(st_b), 32'd0);
  endtask

  run_t runs [7];

  initial begin
    runs[0] = '{mode: 0, fault: 0, restart_at: -1, exp_err: 0, exp_fv: 1'b0, exp_fvec: 3'b000};
    runs[1] = '{mode: 0, fault: 0, restart_at: 10, exp_err: 0, exp_fv: 1'b0, exp_fvec: 3'b000};
    runs[2] = '{mode: 0, fault: 1, restart_at: -1, exp_err: 1, exp_fv: 1'b1, exp_fvec: 3'b111};
    runs[3] = '{mode: 0, fault: 0, restart_at: -1, exp_err: 0, exp_fv: 1'b0, exp_fvec: 3'b000};
    runs[4] = '{mode: 1, fault: 2, restart_at: -1, exp_err: 8, exp_fv: 1'b1, exp_fvec: 3'b000};
    runs[5] = '{mode: 0, fault: 3, restart_at: -1, exp_err: 0, exp_fv: 1'b0, exp_fvec: 3'b000};
    runs[6] = '{mode: 1, fault: 0, restart_at: -1, exp_err: 0, exp_fv: 1'b0, exp_fvec: 3'b000};

    rst = 1'b1; start_w = 1'b0; start_b = 1'b0;
    set_y(0, 3'b000, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_run(runs[i], $sformatf("run%0d", i));
    end

    // Reset mid-run: walk mode with every vector failing, reset taking
    // effect at the edge that ends cycle 12 (vector 3).
    cur_mode = 0;
    for (int k = 0; k <= 12; k++) exp_q.push_back({exp_vec(0, k / HOLD), 1'b1, 1'b0});
    @(negedge clk);
    start_w = 1'b1;
    @(posedge clk);
    #1;
    start_w = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      logic [W-1:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      check("abort_abc_busy_done", 32'({abc_s, busy_s, done_s}), 32'(e));
      set_y(2, exp_vec(0, k / HOLD), k % HOLD);
    end
    check("abort_err_before_rst", 32'(err_w), 32'd3);
    check("abort_fv_before_rst", 32'(fv_w), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("abort");
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    do_run(runs[0], "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
